fp_compare_pipe: RTL and testbench

//  Parametrised, pipelined floating-point comparator for the FPU Add_Sub path and the compare instructions.

---
 rtl/fp_compare_pipe.sv | 130 +++++++++++++
 tb/tb_fp_compare_pipe.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_compare_pipe.sv
// rtl/fp_compare_pipe.sv - two-stage pipelined floating-point comparator with swap/exponent-difference outputs
// Stage 1 registers raw field compares and classification; stage 2 resolves ordering and holds results.
module fp_compare_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int DW = 1 + EXP_W + MAN_W
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             InValid,
  output logic             InReady,
  input  logic [DW-1:0]    OperandA,
  input  logic [DW-1:0]    OperandB,
  input  logic             SignedMode,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [1:0]       Compare,
  output logic             Swap,
  output logic [EXP_W-1:0] ExpDiff
);

  localparam logic [1:0] CMP_EQ = 2'b00;
  localparam logic [1:0] CMP_GT = 2'b01;
  localparam logic [1:0] CMP_LT = 2'b10;
  localparam logic [1:0] CMP_UN = 2'b11;

  logic             sign_a, sign_b;
  logic [EXP_W-1:0] exp_a, exp_b;
  logic [MAN_W-1:0] man_a, man_b;
  logic [EXP_W:0]   exp_sub;
  logic [EXP_W-1:0] exp_abs;

  assign sign_a = OperandA[DW-1];
  assign sign_b = OperandB[DW-1];
  assign exp_a  = OperandA[DW-2 -: EXP_W];
  assign exp_b  = OperandB[DW-2 -: EXP_W];
  assign man_a  = OperandA[MAN_W-1:0];
  assign man_b  = OperandB[MAN_W-1:0];

  // Borrow out of the widened subtract says expB > expA.
  assign exp_sub = {1'b0, exp_a} - {1'b0, exp_b};
  assign exp_abs = exp_sub[EXP_W] ? (exp_b - exp_a) : exp_sub[EXP_W-1:0];

  logic             s1_valid;
  logic             s1_exp_gt, s1_exp_eq, s1_man_gt, s1_man_eq;
  logic             s1_sign_a, s1_sign_b, s1_signed;
  logic             s1_nan_a, s1_nan_b, s1_zero_a, s1_zero_b;
  logic [EXP_W-1:0] s1_exp_diff;

  logic adv1, adv2;

  assign adv2    = ~OutValid | OutReady;
  assign adv1    = ~s1_valid | adv2;
  assign InReady = adv1;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_valid    <= 1'b0;
      s1_exp_gt   <= 1'b0;
      s1_exp_eq   <= 1'b0;
      s1_man_gt   <= 1'b0;
      s1_man_eq   <= 1'b0;
      s1_sign_a   <= 1'b0;
      s1_sign_b   <= 1'b0;
      s1_signed   <= 1'b0;
      s1_nan_a    <= 1'b0;
      s1_nan_b    <= 1'b0;
      s1_zero_a   <= 1'b0;
      s1_zero_b   <= 1'b0;
      s1_exp_diff <= '0;
    end else if (adv1) begin
      s1_valid <= InValid;
      if (InValid) begin
        s1_exp_gt   <= exp_a > exp_b;
        s1_exp_eq   <= exp_a == exp_b;
        s1_man_gt   <= man_a > man_b;
        s1_man_eq   <= man_a == man_b;
        s1_sign_a   <= sign_a;
        s1_sign_b   <= sign_b;
        s1_signed   <= SignedMode;
        s1_nan_a    <= (&exp_a) & (|man_a);
        s1_nan_b    <= (&exp_b) & (|man_b);
        s1_zero_a   <= ~(|exp_a) & ~(|man_a);
        s1_zero_b   <= ~(|exp_b) & ~(|man_b);
        s1_exp_diff <= exp_abs;
      end
    end
  end

  logic       mag_gt, mag_eq;
  logic [1:0] mag_cmp, next_cmp;
  logic       next_swap;

  always_comb begin
    mag_gt    = s1_exp_gt | (s1_exp_eq & s1_man_gt);
    mag_eq    = s1_exp_eq & s1_man_eq;
    next_swap = ~mag_gt & ~mag_eq;
    mag_cmp   = mag_eq ? CMP_EQ : (mag_gt ? CMP_GT : CMP_LT);
    next_cmp  = mag_cmp;
    if (s1_nan_a | s1_nan_b) begin
      next_cmp = CMP_UN;
    end else if (s1_signed) begin
      if (s1_zero_a & s1_zero_b) begin
        next_cmp = CMP_EQ;
      end else if (s1_sign_a != s1_sign_b) begin
        next_cmp = s1_sign_a ? CMP_LT : CMP_GT;
      end else if (s1_sign_a) begin
        // Both negative: larger magnitude is the smaller value.
        next_cmp = mag_eq ? CMP_EQ : (mag_gt ? CMP_LT : CMP_GT);
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      OutValid <= 1'b0;
      Compare  <= CMP_EQ;
      Swap     <= 1'b0;
      ExpDiff  <= '0;
    end else if (adv2) begin
      OutValid <= s1_valid;
      if (s1_valid) begin
        Compare <= next_cmp;
        Swap    <= next_swap;
        ExpDiff <= s1_exp_diff;
      end
    end
  end

endmodule

// File: tb/tb_fp_compare_pipe.sv
// tb/tb_fp_compare_pipe.sv - self-checking bench for fp_compare_pipe
// Reference model orders operands as signed integers built from the packed fields.
module tb_fp_compare_pipe;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int DW    = 32;

  typedef struct packed {
    logic [1:0] cmp;
    logic       swap;
    logic [7:0] diff;
  } res_t;

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic          InValid = 1'b0;
  logic          InReady;
  logic [DW-1:0] OperandA = '0;
  logic [DW-1:0] OperandB = '0;
  logic          SignedMode = 1'b0;
  logic          OutValid;
  logic          OutReady = 1'b1;
  logic [1:0]    Compare;
  logic          Swap;
  logic [7:0]    ExpDiff;

  int n_cmp = 0;
  int n_bad = 0;

  fp_compare_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .InValid(InValid), .InReady(InReady),
    .OperandA(OperandA), .OperandB(OperandB), .SignedMode(SignedMode),
    .OutValid(OutValid), .OutReady(OutReady), .Compare(Compare),
    .Swap(Swap), .ExpDiff(ExpDiff)
  );

  always #5 Clk = ~Clk;

  function automatic res_t ref_model(input logic [31:0] a, input logic [31:0] b, input logic sm);
    res_t   r;
    longint mag_a, mag_b, key_a, key_b;
    int     ea, eb;
    bit     nan_a, nan_b;
    mag_a = longint'(a[30:0]);
    mag_b = longint'(b[30:0]);
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    nan_a = (ea == 255) && (a[22:0] != 0);
    nan_b = (eb == 255) && (b[22:0] != 0);
    key_a = (sm && a[31]) ? -mag_a : mag_a;
    key_b = (sm && b[31]) ? -mag_b : mag_b;
    r.swap = mag_b > mag_a;
    r.diff = 8'((ea > eb) ? (ea - eb) : (eb - ea));
    if (nan_a || nan_b)     r.cmp = 2'b11;
    else if (key_a == key_b) r.cmp = 2'b00;
    else if (key_a > key_b)  r.cmp = 2'b01;
    else                     r.cmp = 2'b10;
    return r;
  endfunction

  task automatic gen_pair(output logic [31:0] a, output logic [31:0] b, output logic sm);
    int k;
    k = $urandom_range(0, 6);
    a = $urandom;
    b = $urandom;
    case (k)
      1: b = a;
      2: b = a ^ 32'h8000_0000;
      3: begin a[30:0] = '0; b[30:0] = '0; end
      4: b[30:23] = a[30:23];
      5: a[30:23] = 8'hFF;
      6: begin b[30:23] = 8'hFF; if ($urandom_range(0, 1) == 1) b[22:0] = '0; end
      default: ;
    endcase
    sm = 1'($urandom_range(0, 1));
  endtask

  task automatic test_reset;
    Reset_n = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    n_cmp++; if (OutValid !== 1'b0) begin n_bad++; $display("FAIL reset_outvalid: got %0b want 0", OutValid); end
    n_cmp++; if ({Compare, Swap, ExpDiff} !== 11'd0) begin n_bad++; $display("FAIL reset_outputs: got %0h want 0", {Compare, Swap, ExpDiff}); end
    Reset_n = 1'b1;
    #1;
    n_cmp++; if (InReady !== 1'b1) begin n_bad++; $display("FAIL reset_inready: got %0b want 1", InReady); end
    @(posedge Clk); #1;
  endtask

  task automatic test_directed;
    logic [31:0] va [9];
    logic [31:0] vb [9];
    logic        vs [9];
    res_t        ve [9];
    va[0] = 32'h3F800000; vb[0] = 32'h40000000; vs[0] = 1; ve[0] = '{2'b10, 1'b1, 8'd1};
    va[1] = 32'h80000000; vb[1] = 32'h00000000; vs[1] = 1; ve[1] = '{2'b00, 1'b0, 8'd0};
    va[2] = 32'h80000000; vb[2] = 32'h00000000; vs[2] = 0; ve[2] = '{2'b00, 1'b0, 8'd0};
    va[3] = 32'hC0000000; vb[3] = 32'hBF800000; vs[3] = 1; ve[3] = '{2'b10, 1'b0, 8'd1};
    va[4] = 32'hC0000000; vb[4] = 32'hBF800000; vs[4] = 0; ve[4] = '{2'b01, 1'b0, 8'd1};
    va[5] = 32'h7FC00000; vb[5] = 32'h7F800000; vs[5] = 1; ve[5] = '{2'b11, 1'b0, 8'd0};
    va[6] = 32'h7F800000; vb[6] = 32'h7F7FFFFF; vs[6] = 1; ve[6] = '{2'b01, 1'b0, 8'd1};
    va[7] = 32'h7FC00000; vb[7] = 32'h7F800000; vs[7] = 0; ve[7] = '{2'b11, 1'b0, 8'd0};
    va[8] = 32'h00000001; vb[8] = 32'h80000002; vs[8] = 1; ve[8] = '{2'b01, 1'b1, 8'd0};
    OutReady = 1'b1;
    for (int i = 0; i < 9; i++) begin
      OperandA = va[i]; OperandB = vb[i]; SignedMode = vs[i]; InValid = 1'b1;
      #1;
      n_cmp++; if (InReady !== 1'b1) begin n_bad++; $display("FAIL dir%0d_inready: got %0b want 1", i, InReady); end
      @(posedge Clk); #1;
      InValid = 1'b0;
      n_cmp++; if (OutValid !== 1'b0) begin n_bad++; $display("FAIL dir%0d_early: got OutValid %0b want 0", i, OutValid); end
      @(posedge Clk); #1;
      n_cmp++; if (OutValid !== 1'b1) begin n_bad++; $display("FAIL dir%0d_latency: got OutValid %0b want 1", i, OutValid); end
      n_cmp++; if (Compare !== ve[i].cmp) begin n_bad++; $display("FAIL dir%0d_compare: got %0b want %0b", i, Compare, ve[i].cmp); end
      n_cmp++; if (Swap !== ve[i].swap) begin n_bad++; $display("FAIL dir%0d_swap: got %0b want %0b", i, Swap, ve[i].swap); end
      n_cmp++; if (ExpDiff !== ve[i].diff) begin n_bad++; $display("FAIL dir%0d_expdiff: got %0d want %0d", i, ExpDiff, ve[i].diff); end
      @(posedge Clk); #1;
      n_cmp++; if (OutValid !== 1'b0) begin n_bad++; $display("FAIL dir%0d_drain: got OutValid %0b want 0", i, OutValid); end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] a, b;
    logic        sm;
    res_t        exp_q [8];
    OutReady = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c < 8) begin
        gen_pair(a, b, sm);
        exp_q[c] = ref_model(a, b, sm);
        OperandA = a; OperandB = b; SignedMode = sm; InValid = 1'b1;
      end else begin
        InValid = 1'b0;
      end
      #1;
      if (c < 8) begin
        n_cmp++; if (InReady !== 1'b1) begin n_bad++; $display("FAIL b2b_inready c%0d: got %0b want 1", c, InReady); end
      end
      if (c >= 2 && c < 10) begin
        n_cmp++; if (OutValid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid c%0d: got %0b want 1", c, OutValid); end
        n_cmp++; if ({Compare, Swap, ExpDiff} !== exp_q[c-2]) begin n_bad++; $display("FAIL b2b_result c%0d: got %0h want %0h", c, {Compare, Swap, ExpDiff}, exp_q[c-2]); end
      end else begin
        n_cmp++; if (OutValid !== 1'b0) begin n_bad++; $display("FAIL b2b_idle c%0d: got %0b want 0", c, OutValid); end
      end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_stall;
    logic [31:0] pa [4];
    logic [31:0] pb [4];
    logic        ps [4];
    res_t        pe [4];
    int idx = 0, rcv = 0;
    for (int i = 0; i < 4; i++) begin
      gen_pair(pa[i], pb[i], ps[i]);
      pe[i] = ref_model(pa[i], pb[i], ps[i]);
    end
    for (int c = 0; c < 40 && rcv < 4; c++) begin
      OutReady = (c >= 7);
      InValid  = (idx < 4);
      if (idx < 4) begin OperandA = pa[idx]; OperandB = pb[idx]; SignedMode = ps[idx]; end
      #1;
      if (c < 2) begin
        n_cmp++; if (InReady !== 1'b1) begin n_bad++; $display("FAIL stall_fill c%0d: got InReady %0b want 1", c, InReady); end
      end else if (c < 7) begin
        n_cmp++; if (InReady !== 1'b0) begin n_bad++; $display("FAIL stall_inready c%0d: got %0b want 0", c, InReady); end
        n_cmp++; if (OutValid !== 1'b1) begin n_bad++; $display("FAIL stall_valid c%0d: got %0b want 1", c, OutValid); end
        n_cmp++; if ({Compare, Swap, ExpDiff} !== pe[0]) begin n_bad++; $display("FAIL stall_hold c%0d: got %0h want %0h", c, {Compare, Swap, ExpDiff}, pe[0]); end
      end
      if (InValid && InReady) idx++;
      if (OutValid && OutReady) begin
        n_cmp++;
        if (rcv >= 4 || {Compare, Swap, ExpDiff} !== pe[rcv]) begin
          n_bad++; $display("FAIL stall_order #%0d: got %0h want %0h", rcv, {Compare, Swap, ExpDiff}, pe[rcv < 4 ? rcv : 3]);
        end
        rcv++;
      end
      @(posedge Clk); #1;
    end
    InValid = 1'b0;
    n_cmp++; if (rcv !== 4) begin n_bad++; $display("FAIL stall_count: got %0d results want 4", rcv); end
    for (int c = 0; c < 3; c++) begin
      n_cmp++; if (OutValid !== 1'b0) begin n_bad++; $display("FAIL stall_dup c%0d: got OutValid %0b want 0", c, OutValid); end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_reset_mid_stall;
    logic [31:0] a, b;
    logic        sm;
    OutReady = 1'b0;
    for (int c = 0; c < 2; c++) begin
      gen_pair(a, b, sm);
      OperandA = a; OperandB = b; SignedMode = sm; InValid = 1'b1;
      @(posedge Clk); #1;
    end
    InValid = 1'b0;
    @(posedge Clk); #1;
    n_cmp++; if (OutValid !== 1'b1 || InReady !== 1'b0) begin n_bad++; $display("FAIL rst_prefill: got valid %0b ready %0b want 1 0", OutValid, InReady); end
    #2 Reset_n = 1'b0;
    #1;
    n_cmp++; if (OutValid !== 1'b0) begin n_bad++; $display("FAIL rst_async_valid: got %0b want 0", OutValid); end
    n_cmp++; if ({Compare, Swap, ExpDiff} !== 11'd0) begin n_bad++; $display("FAIL rst_async_outputs: got %0h want 0", {Compare, Swap, ExpDiff}); end
    @(posedge Clk); #3 Reset_n = 1'b1;
    @(posedge Clk); #1;
    OutReady = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      n_cmp++; if (InReady !== 1'b1) begin n_bad++; $display("FAIL rst_release_ready c%0d: got %0b want 1", c, InReady); end
      n_cmp++; if (OutValid !== 1'b0) begin n_bad++; $display("FAIL rst_stale c%0d: got OutValid %0b want 0", c, OutValid); end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_random_flow;
    res_t        sb [$];
    logic [31:0] a, b;
    logic        sm;
    int sent = 0, rcv = 0;
    bit have = 0;
    for (int c = 0; c < 2000 && rcv < 200; c++) begin
      if (!have && sent < 200) begin
        gen_pair(a, b, sm);
        have = 1;
      end
      InValid  = have && ($urandom_range(0, 3) != 0);
      OperandA = a; OperandB = b; SignedMode = sm;
      OutReady = ($urandom_range(0, 2) != 0);
      #1;
      if (InValid && InReady) begin
        sb.push_back(ref_model(a, b, sm));
        sent++; have = 0;
      end
      if (OutValid && OutReady) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++; $display("FAIL rand_extra: got result %0h with nothing pending", {Compare, Swap, ExpDiff});
        end else begin
          if ({Compare, Swap, ExpDiff} !== sb[0]) begin
            n_bad++; $display("FAIL rand_result #%0d: got %0h want %0h", rcv, {Compare, Swap, ExpDiff}, sb[0]);
          end
          void'(sb.pop_front());
        end
        rcv++;
      end
      @(posedge Clk); #1;
    end
    InValid = 1'b0;
    n_cmp++; if (rcv !== 200) begin n_bad++; $display("FAIL rand_count: got %0d results want 200", rcv); end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_back_to_back;
    test_stall;
    test_reset_mid_stall;
    test_random_flow;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
